// File: rtl/dcache_nway_if.sv
// CPU data port and physical-memory line port of the set-associative L1 data cache.
// The master side issues CPU requests and answers line transfers; the cache is the slave.
interface dcache_nway_if;
   logic         mem_read;
   logic         mem_write;
   logic [1:0]   mem_byte_enable;
   logic [15:0]  mem_address;
   logic [15:0]  mem_wdata;
   logic         mem_resp;
   logic [15:0]  mem_rdata;
   logic         pmem_read;
   logic         pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata;
   logic         pmem_resp;
   logic [127:0] pmem_rdata;

   modport master (
      output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      input  mem_resp, mem_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata,
      output pmem_resp, pmem_rdata
   );

   modport slave (
      input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
      output mem_resp, mem_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata,
      input  pmem_resp, pmem_rdata
   );
endinterface

// File: rtl/dcache_nway.sv
// Write-back, write-allocate N-way L1 data cache with tree pseudo-LRU; hits respond combinationally,
// misses stall the held CPU request through WRITEBACK/ALLOCATE until pmem_resp.
module dcache_nway #(
   parameter int NUM_WAYS = 2,
   parameter int NUM_SETS = 8
) (
   input  logic         clk,
   input  logic         rst,
   dcache_nway_if.slave bus
);
   localparam int IDX   = $clog2(NUM_SETS);
   localparam int TAGW  = 12 - IDX;
   localparam int WAYW  = $clog2(NUM_WAYS);
   localparam int PLRUW = NUM_WAYS - 1;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] WRITEBACK = 2'd1;
   localparam logic [1:0] ALLOCATE  = 2'd2;

   logic [1:0]          state, state_next;
   logic [WAYW-1:0]     victim;

   logic [NUM_SETS-1:0] valid [NUM_WAYS];
   logic [NUM_SETS-1:0] dirty [NUM_WAYS];
   logic [PLRUW-1:0]    plru  [NUM_SETS];
   logic [TAGW-1:0]     tags  [NUM_WAYS][NUM_SETS];
   logic [127:0]        lines [NUM_WAYS][NUM_SETS];

   logic [IDX-1:0]      index;
   logic [TAGW-1:0]     tag;
   logic [6:0]          word_bit;
   logic                addr_lsb_unused;

   assign index           = bus.mem_address[3+IDX:4];
   assign tag             = bus.mem_address[15:4+IDX];
   assign word_bit        = {bus.mem_address[3:1], 4'h0};
   assign addr_lsb_unused = bus.mem_address[0];

   // ---------------- datapath: lookup, victim choice, word merge ----------------
   logic            hit, inv_found;
   logic [WAYW-1:0] hit_way, inv_way, plru_vic, fill_way;
   logic [PLRUW-1:0] plru_cur, plru_upd;
   logic [127:0]    hit_line, merged_line;

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid[w][index] && tags[w][index] == tag) begin
            hit     = 1'b1;
            hit_way = WAYW'(w);
         end
         if (!valid[w][index] && !inv_found) begin
            inv_found = 1'b1;
            inv_way   = WAYW'(w);
         end
      end
   end

   assign plru_cur = plru[index];
   assign fill_way = inv_found ? inv_way : plru_vic;

   // Each PLRU bit points at the side to evict; an access flips its path away from the used way.
   if (NUM_WAYS == 2) begin : g_plru2
      assign plru_vic = plru_cur;
      assign plru_upd = ~hit_way;
   end else begin : g_plru4
      assign plru_vic = plru_cur[0] ? {1'b1, plru_cur[2]} : {1'b0, plru_cur[1]};
      always_comb begin
         plru_upd    = plru_cur;
         plru_upd[0] = ~hit_way[1];
         if (hit_way[1]) plru_upd[2] = ~hit_way[0];
         else            plru_upd[1] = ~hit_way[0];
      end
   end

   assign hit_line = lines[hit_way][index];

   always_comb begin
      merged_line = hit_line;
      if (bus.mem_byte_enable[0]) merged_line[word_bit +: 8]         = bus.mem_wdata[7:0];
      if (bus.mem_byte_enable[1]) merged_line[word_bit + 7'd8 +: 8]  = bus.mem_wdata[15:8];
   end

   // ---------------- control ----------------
   logic req, is_write, do_hit, fill_done;

   assign req       = bus.mem_read | bus.mem_write;
   assign is_write  = bus.mem_write;
   assign do_hit    = (state == IDLE) && req && hit;
   assign fill_done = (state == ALLOCATE) && bus.pmem_resp;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:      if (req && !hit)
                       state_next = (valid[fill_way][index] && dirty[fill_way][index]) ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (bus.pmem_resp) state_next = ALLOCATE;
         ALLOCATE:  if (bus.pmem_resp) state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         victim <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE) victim <= fill_way;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            valid[w] <= '0;
            dirty[w] <= '0;
         end
         for (int s = 0; s < NUM_SETS; s++) plru[s] <= '0;
      end else begin
         if (fill_done) begin
            valid[victim][index] <= 1'b1;
            dirty[victim][index] <= 1'b0;
         end
         if (do_hit) begin
            plru[index] <= plru_upd;
            if (is_write) dirty[hit_way][index] <= 1'b1;
         end
      end
   end

   // Tag and line storage carry no reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         tags[victim][index]  <= tag;
         lines[victim][index] <= bus.pmem_rdata;
      end else if (do_hit && is_write) begin
         lines[hit_way][index] <= merged_line;
      end
   end

   assign bus.mem_resp     = do_hit;
   assign bus.mem_rdata    = hit_line[word_bit +: 16];
   assign bus.pmem_write   = (state == WRITEBACK);
   assign bus.pmem_read    = (state == ALLOCATE);
   assign bus.pmem_address = (state == WRITEBACK) ? {tags[victim][index], index, 4'h0}
                                                  : {tag, index, 4'h0};
   assign bus.pmem_wdata   = lines[victim][index];
endmodule

// File: tb/tb_dcache_nway.sv
// Drives a 2-way and a 4-way cache against a flat CPU-view memory plus an LRU residency model.
module tb_dcache_nway;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int          sel;
   logic        req_rd, req_wr;
   logic [1:0]  ben;
   logic [15:0] addr, wdata;
   logic        presp  [2];
   logic [127:0] prdata [2];
   logic        o_resp [2], o_pread [2], o_pwrite [2];
   logic [15:0] o_rdata [2], o_pa [2];
   logic [127:0] o_pwdata [2];

   int lat_rd, lat_wb;
   int n_chk = 0, n_fail = 0;
   int n_wb [2], n_rd [2];
   logic [15:0]  wb_addr [2], rd_addr [2];
   logic [127:0] wb_data [2];

   logic [127:0] pmem [2][4096];
   logic [127:0] gold [2][4096];
   logic [11:0]  lru [8][$];
   bit           mdirty [int];

   dcache_nway_if bus2 ();
   dcache_nway_if bus4 ();

   dcache_nway #(.NUM_WAYS(2), .NUM_SETS(8)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2));
   dcache_nway #(.NUM_WAYS(4), .NUM_SETS(8)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

   assign bus2.mem_read        = req_rd && sel == 0;
   assign bus2.mem_write       = req_wr && sel == 0;
   assign bus2.mem_byte_enable = ben;
   assign bus2.mem_address     = addr;
   assign bus2.mem_wdata       = wdata;
   assign bus2.pmem_resp       = presp[0];
   assign bus2.pmem_rdata      = prdata[0];
   assign o_resp[0]   = bus2.mem_resp;
   assign o_rdata[0]  = bus2.mem_rdata;
   assign o_pread[0]  = bus2.pmem_read;
   assign o_pwrite[0] = bus2.pmem_write;
   assign o_pa[0]     = bus2.pmem_address;
   assign o_pwdata[0] = bus2.pmem_wdata;

   assign bus4.mem_read        = req_rd && sel == 1;
   assign bus4.mem_write       = req_wr && sel == 1;
   assign bus4.mem_byte_enable = ben;
   assign bus4.mem_address     = addr;
   assign bus4.mem_wdata       = wdata;
   assign bus4.pmem_resp       = presp[1];
   assign bus4.pmem_rdata      = prdata[1];
   assign o_resp[1]   = bus4.mem_resp;
   assign o_rdata[1]  = bus4.mem_rdata;
   assign o_pread[1]  = bus4.pmem_read;
   assign o_pwrite[1] = bus4.pmem_write;
   assign o_pa[1]     = bus4.pmem_address;
   assign o_pwdata[1] = bus4.pmem_wdata;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Memory answers a strobe with a one-cycle pmem_resp 'latency' cycles after it first appears.
   task automatic pmem_serve(input int d);
      int n;
      logic [11:0] ln;
      n = 0;
      presp[d]  = 1'b0;
      prdata[d] = '0;
      forever begin
         @(posedge clk); #1;
         presp[d] = 1'b0;
         if (rst || !(o_pread[d] || o_pwrite[d])) n = 0;
         else begin
            n++;
            if (n == (o_pwrite[d] ? lat_wb : lat_rd) + 1) begin
               ln = o_pa[d][15:4];
               chk("pmem_excl", 128'(o_pread[d] & o_pwrite[d]), 128'(0));
               chk("pmem_align", 128'(o_pa[d][3:0]), 128'(0));
               if (o_pwrite[d]) begin
                  chk("wb_data", o_pwdata[d], gold[d][ln]);
                  pmem[d][ln] = o_pwdata[d];
                  n_wb[d]++;
                  wb_addr[d] = o_pa[d];
                  wb_data[d] = o_pwdata[d];
               end else begin
                  prdata[d] = pmem[d][ln];
                  n_rd[d]++;
                  rd_addr[d] = o_pa[d];
               end
               presp[d] = 1'b1;
               n = 0;
            end
         end
      end
   endtask

   task automatic reset_model();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4096; i++) gold[d][i] = pmem[d][i];
      for (int s = 0; s < 8; s++) lru[s].delete();
      mdirty.delete();
   endtask

   task automatic do_reset();
      req_rd = 1'b0;
      req_wr = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      reset_model();
   endtask

   // Entered and left 1 time unit after a rising edge; lat counts cycles until mem_resp.
   task automatic access(input int d, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                         input logic [1:0] be, output logic [15:0] rd, output int lat);
      logic [127:0] ln;
      int b;
      sel = d; addr = a; wdata = wd; ben = be;
      req_wr = wr;
      req_rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      lat = 0;
      rd  = '0;
      forever begin
         #2;
         if (o_resp[d]) begin
            rd = o_rdata[d];
            break;
         end
         @(posedge clk); #1;
         lat++;
         if (lat > 400) begin
            chk("resp_timeout", 128'(lat), 128'(0));
            break;
         end
      end
      @(posedge clk); #1;
      req_rd = 1'b0;
      req_wr = 1'b0;
      b  = int'(a[3:1]) * 16;
      ln = gold[d][a[15:4]];
      if (wr) begin
         if (be[0]) ln[b +: 8]     = wd[7:0];
         if (be[1]) ln[b + 8 +: 8] = wd[15:8];
         gold[d][a[15:4]] = ln;
      end else begin
         chk("rdata", 128'(rd), 128'(ln[b +: 16]));
      end
   endtask

   task automatic rand_phase(input int d, input int n);
      logic [15:0] a, rd;
      logic [11:0] line, vic;
      bit wr, exp_wb;
      int lat, exp_lat, wb0, idx, pos;
      for (int k = 0; k < n; k++) begin
         idx = $urandom_range(0, 1);
         a = 16'(($urandom_range(0, 4) << 7) | (idx << 4) | ($urandom_range(0, 15)));
         wr = 1'($urandom_range(0, 1));
         lat_rd = $urandom_range(1, 4);
         lat_wb = $urandom_range(1, 4);
         line = a[15:4];
         wb0 = n_wb[d];
         exp_wb = 1'b0;
         exp_lat = 0;
         vic = '0;
         if (d == 0) begin
            pos = -1;
            for (int i = 0; i < lru[idx].size(); i++) if (lru[idx][i] == line) pos = i;
            if (pos >= 0) lru[idx].delete(pos);
            else begin
               exp_lat = 2 + lat_rd;
               if (lru[idx].size() == 2) begin
                  vic = lru[idx].pop_back();
                  if (mdirty[int'(vic)]) begin
                     exp_wb = 1'b1;
                     exp_lat += 1 + lat_wb;
                  end
                  mdirty[int'(vic)] = 1'b0;
               end
               mdirty[int'(line)] = 1'b0;
            end
            lru[idx].push_front(line);
            if (wr) mdirty[int'(line)] = 1'b1;
         end
         access(d, wr, a, 16'($urandom), 2'($urandom), rd, lat);
         if (d == 0) begin
            chk("rand_lat", 128'(lat), 128'(exp_lat));
            chk("rand_wb", 128'(n_wb[d] - wb0), 128'(exp_wb));
            if (exp_wb) chk("rand_wb_addr", 128'(wb_addr[d]), 128'({vic, 4'h0}));
         end
      end
   endtask

   initial begin
      logic [15:0] rd;
      int lat, r0, w0;
      rst = 1'b1;
      req_rd = 1'b0; req_wr = 1'b0; sel = 0;
      addr = '0; wdata = '0; ben = '0;
      lat_rd = 3; lat_wb = 2;
      for (int d = 0; d < 2; d++) begin
         n_wb[d] = 0; n_rd[d] = 0;
         wb_addr[d] = '0; rd_addr[d] = '0; wb_data[d] = '0;
         for (int i = 0; i < 4096; i++) pmem[d][i] = {$urandom, $urandom, $urandom, $urandom};
      end
      pmem[0][12'h004][31:16] = 16'h1234;
      pmem[0][12'h004][63:48] = 16'hA5A5;
      fork
         pmem_serve(0);
         pmem_serve(1);
      join_none

      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_resp", 128'(o_resp[d]), 128'(0));
         chk("rst_pread", 128'(o_pread[d]), 128'(0));
         chk("rst_pwrite", 128'(o_pwrite[d]), 128'(0));
      end
      do_reset();

      // cold read miss, fill latency 3
      r0 = n_rd[0]; w0 = n_wb[0];
      access(0, 1'b0, 16'h0046, 16'h0, 2'b00, rd, lat);
      chk("t1_lat", 128'(lat), 128'(5));
      chk("t1_rdata", 128'(rd), 128'(16'hA5A5));
      chk("t1_nrd", 128'(n_rd[0] - r0), 128'(1));
      chk("t1_raddr", 128'(rd_addr[0]), 128'(16'h0040));
      chk("t1_nwb", 128'(n_wb[0] - w0), 128'(0));

      // write hit, low byte only
      r0 = n_rd[0]; w0 = n_wb[0];
      access(0, 1'b1, 16'h0042, 16'hBEEF, 2'b01, rd, lat);
      chk("t2_wlat", 128'(lat), 128'(0));
      access(0, 1'b0, 16'h0042, 16'h0, 2'b00, rd, lat);
      chk("t2_rlat", 128'(lat), 128'(0));
      chk("t2_rdata", 128'(rd), 128'(16'h12EF));
      chk("t2_pmem", 128'((n_rd[0] - r0) + (n_wb[0] - w0)), 128'(0));

      // clean LRU eviction
      do_reset();
      w0 = n_wb[0];
      access(0, 1'b0, 16'h0040, 16'h0, 2'b00, rd, lat);
      access(0, 1'b0, 16'h00C0, 16'h0, 2'b00, rd, lat);
      access(0, 1'b0, 16'h0040, 16'h0, 2'b00, rd, lat);
      access(0, 1'b0, 16'h0140, 16'h0, 2'b00, rd, lat);
      chk("t3_nwb", 128'(n_wb[0] - w0), 128'(0));
      access(0, 1'b0, 16'h0040, 16'h0, 2'b00, rd, lat);
      chk("t3_hit40", 128'(lat), 128'(0));
      access(0, 1'b0, 16'h00C0, 16'h0, 2'b00, rd, lat);
      chk("t3_missC0", 128'(lat), 128'(2 + lat_rd));

      // dirty eviction
      do_reset();
      access(0, 1'b1, 16'h0040, 16'h5555, 2'b11, rd, lat);
      access(0, 1'b0, 16'h00C0, 16'h0, 2'b00, rd, lat);
      w0 = n_wb[0];
      access(0, 1'b0, 16'h0140, 16'h0, 2'b00, rd, lat);
      chk("t4_lat", 128'(lat), 128'(3 + lat_rd + lat_wb));
      chk("t4_nwb", 128'(n_wb[0] - w0), 128'(1));
      chk("t4_wbaddr", 128'(wb_addr[0]), 128'(16'h0040));
      chk("t4_wbdata", 128'(wb_data[0][15:0]), 128'(16'h5555));
      chk("t4_raddr", 128'(rd_addr[0]), 128'(16'h0140));

      // reset while writing back
      do_reset();
      access(0, 1'b1, 16'h0040, 16'h6666, 2'b11, rd, lat);
      access(0, 1'b0, 16'h00C0, 16'h0, 2'b00, rd, lat);
      lat_wb = 30;
      sel = 0; addr = 16'h0140; req_wr = 1'b0; req_rd = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (o_pwrite[0]) break;
      end
      chk("t5_pwrite_seen", 128'(o_pwrite[0]), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("t5_pwrite_drop", 128'(o_pwrite[0]), 128'(0));
      chk("t5_pread_idle", 128'(o_pread[0]), 128'(0));
      req_rd = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      reset_model();
      lat_wb = 2;
      r0 = n_rd[0]; w0 = n_wb[0];
      access(0, 1'b0, 16'h0040, 16'h0, 2'b00, rd, lat);
      chk("t5_miss", 128'(lat), 128'(2 + lat_rd));
      chk("t5_nrd", 128'(n_rd[0] - r0), 128'(1));
      chk("t5_raddr", 128'(rd_addr[0]), 128'(16'h0040));
      chk("t5_nwb", 128'(n_wb[0] - w0), 128'(0));

      // 4-way tree PLRU victim
      do_reset();
      w0 = n_wb[1];
      access(1, 1'b0, 16'h0040, 16'h0, 2'b00, rd, lat);
      access(1, 1'b0, 16'h00C0, 16'h0, 2'b00, rd, lat);
      access(1, 1'b0, 16'h0140, 16'h0, 2'b00, rd, lat);
      access(1, 1'b0, 16'h01C0, 16'h0, 2'b00, rd, lat);
      access(1, 1'b0, 16'h0040, 16'h0, 2'b00, rd, lat);
      chk("t6_hit40a", 128'(lat), 128'(0));
      access(1, 1'b0, 16'h0240, 16'h0, 2'b00, rd, lat);
      chk("t6_raddr", 128'(rd_addr[1]), 128'(16'h0240));
      chk("t6_nwb", 128'(n_wb[1] - w0), 128'(0));
      access(1, 1'b0, 16'h0040, 16'h0, 2'b00, rd, lat);
      chk("t6_hit40", 128'(lat), 128'(0));
      access(1, 1'b0, 16'h00C0, 16'h0, 2'b00, rd, lat);
      chk("t6_hitC0", 128'(lat), 128'(0));
      access(1, 1'b0, 16'h01C0, 16'h0, 2'b00, rd, lat);
      chk("t6_hit1C0", 128'(lat), 128'(0));
      access(1, 1'b0, 16'h0140, 16'h0, 2'b00, rd, lat);
      chk("t6_miss140", 128'(lat), 128'(2 + lat_rd));

      do_reset();
      rand_phase(0, 300);
      do_reset();
      rand_phase(1, 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/dcache_nway.md
# dcache_nway

Parametrised, write-back, write-allocate, set-associative L1 data cache for the LC-3b core. It sits between the CPU data port (16-bit word, 2-bit byte mask) and physical memory (128-bit cacheline). It generalises the fixed 2-way data cache to a configurable way count and set count, with tree pseudo-LRU replacement and asynchronous reset of all state. Datapath and control are split internally, as in the existing caches.

## Interface

Parameters:
- NUM_WAYS, 2: associativity; legal values 2 or 4.
- NUM_SETS, 8: sets per way; power of 2, from 2 to 64.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_byte_enable  in  2  byte mask for writes.
- mem_address  in  16  byte address.
- mem_wdata  in  16  write data.
- mem_resp  out  1  one-cycle completion pulse.
- mem_rdata  out  16  read data; valid when mem_resp=1.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  16  line address; bits [3:0] are always 0.
- pmem_wdata  out  128  victim line.
- pmem_resp  in  1  memory done.
- pmem_rdata  in  128  fill line.

## Operation

- Address fields:
  - offset = addr[3:0]; word select = addr[3:1].
  - index = addr[3+IDX:4], with IDX = log2(NUM_SETS).
  - tag = addr[15:4+IDX].
- Per way and set: valid, dirty, tag, and a 128-bit data line. Per set: NUM_WAYS-1 PLRU bits.
- If mem_read and mem_write are both asserted, the request is treated as a write.
- State machine: IDLE, WRITEBACK, ALLOCATE.
- IDLE, request present:
  - Hit: one way has valid=1 and a matching tag.
  - Read hit: mem_rdata = word[addr[3:1]] of the hit line.
  - Write hit: merge mem_wdata into that word per byte enable; bit 0 selects [7:0], bit 1 selects [15:8]. Set dirty=1.
  - Any hit: assert mem_resp and update PLRU.
  - Miss, victim dirty: go to WRITEBACK. Otherwise go to ALLOCATE.
- Victim selection: the lowest-numbered invalid way if one exists; otherwise the PLRU victim.
- Victim is latched on IDLE exit and stays fixed through ALLOCATE.
- PLRU rule: each bit points toward the victim side. On access to way w, every bit on w's path is set to point away from w.
  - NUM_WAYS=2: one bit.
  - NUM_WAYS=4: root bit selects the pair; leaf bits select within the pair.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 4'h0}, pmem_wdata=victim line.
  - Stays until pmem_resp, then goes to ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmem_address={req tag, index, 4'h0}.
  - On pmem_resp: write pmem_rdata into the victim way; set tag=req tag, valid=1, dirty=0. Go to IDLE.
  - The still-held request then hits in IDLE. Write-miss data is merged at that point.
- Fill and writeback do not update PLRU; only the completing hit does.
- Reset:
  - Clears every valid, dirty and PLRU bit and puts the machine in IDLE.
  - Tag and data arrays are not reset.
  - Reset mid-operation aborts any pmem transaction immediately. A CPU request still held after reset is re-evaluated from IDLE as a miss.

## Timing

- Reset values: mem_resp=0, pmem_read=0, pmem_write=0, state=IDLE. pmem_address, pmem_wdata and mem_rdata are don't-care.
- Hit: mem_resp is combinational in the cycle the request is presented in IDLE. Array and PLRU updates occur on that clock edge.
- Clean miss:
  - pmem_read rises in the cycle after detection.
  - mem_resp occurs 1 cycle after the pmem_resp cycle.
  - Total = 2 + memory latency cycles.
- Dirty miss: adds 1 + writeback latency cycles before ALLOCATE.
- pmem_read and pmem_write are mutually exclusive.
- Each strobe is held with a stable address until the cycle of pmem_resp. It drops the following cycle, or asynchronously on rst.
- pmem_resp outside WRITEBACK/ALLOCATE is ignored.
- Requests without a prior mem_resp must stay stable; a changing address mid-miss is illegal.

## Test plan

Default configuration (2 ways, 8 sets) unless stated; index = addr[6:4].

1. Cold read 0x0046 after reset:
   - pmem_read with pmem_address=0x0040, no pmem_write.
   - Fill line with word3=0xA5A5, memory latency 3.
   - Required: mem_resp exactly 5 cycles after the request, mem_rdata=0xA5A5.
2. Line resident with word1=0x1234; write 0x0042, data 0xBEEF, mask 2'b01:
   - Required: mem_resp in the same cycle, no pmem activity.
   - Read 0x0042 then returns 0x12EF.
3. Clean LRU eviction: read 0x0040, read 0x00C0, read 0x0040, then read 0x0140.
   - Required: no pmem_write; the 0x00C0 way is replaced.
   - Re-reading 0x0040 hits; re-reading 0x00C0 misses.
4. Dirty eviction: write 0x0040=0x5555 (mask 2'b11), read 0x00C0, read 0x0140.
   - Required: pmem_write at 0x0040 with pmem_wdata[15:0]=0x5555.
   - Then pmem_read at 0x0140.
5. Reset during WRITEBACK: assert rst while pmem_write=1.
   - Required: pmem_write=0 in the same cycle.
   - After release, read 0x0040 misses and issues pmem_read 0x0040.
6. NUM_WAYS=4: fill 0x0040, 0x00C0, 0x0140, 0x01C0 in that order, read 0x0040, then read 0x0240.
   - Required: evicts way 2 (0x0140); the other three lines still hit.
